// File: rtl/mem_write_checker.sv
// mem_write_checker
//   Self-checking monitor for the processor data-memory store port. A table
//   of expected (address, data) stores is programmed while IDLE. After
//   `start`, observed stores are matched against the active entries, either
//   in index order (ORDERED=1) or in any order (ORDERED=0). The checker ends
//   in a sticky PASS, FAIL or TOUT verdict that is held until the next `start`.
//
// Ports
//   clk, reset        : clock, asynchronous active-low reset
//   cfg_we/idx/addr/data : table write port (IDLE only, idx >= NUM_CHECKS ignored)
//   cfg_len           : active entry count, sampled on start, saturated to NUM_CHECKS
//   start             : arm the checker (IDLE or any verdict state)
//   MemWriteM/DataAdr/WriteData : observed store port
//   done/pass/fail/timeout : verdict flags (decoded from the state register)
//   match_count       : entries matched so far
//   fail_idx/fail_data: mismatching entry index and the offending store data
//   cycles            : ARMED cycles elapsed
module mem_write_checker #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int NUM_CHECKS = 8,
   parameter int ORDERED    = 1,
   parameter int TIMEOUT    = 4096,
   localparam int IDX_W     = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1,
   localparam int LEN_W     = IDX_W + 1,
   localparam int CNT_W     = $clog2(TIMEOUT + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cfg_we,
   input  logic [IDX_W-1:0]  cfg_idx,
   input  logic [ADDR_W-1:0] cfg_addr,
   input  logic [DATA_W-1:0] cfg_data,
   input  logic [LEN_W-1:0]  cfg_len,
   input  logic              start,
   input  logic              MemWriteM,
   input  logic [ADDR_W-1:0] DataAdr,
   input  logic [DATA_W-1:0] WriteData,
   output logic              done,
   output logic              pass,
   output logic              fail,
   output logic              timeout,
   output logic [LEN_W-1:0]  match_count,
   output logic [IDX_W-1:0]  fail_idx,
   output logic [DATA_W-1:0] fail_data,
   output logic [CNT_W-1:0]  cycles
);

   typedef enum logic [2:0] {S_IDLE, S_ARMED, S_PASS, S_FAIL, S_TOUT} state_t;

   state_t                r_state, w_state_nx;
   logic [ADDR_W-1:0]     r_addr [NUM_CHECKS];
   logic [DATA_W-1:0]     r_data [NUM_CHECKS];
   logic [NUM_CHECKS-1:0] r_matched, w_matched_nx;
   logic [LEN_W-1:0]      r_len, w_len_nx;
   logic [LEN_W-1:0]      r_match_count, w_mc_nx;
   logic [IDX_W-1:0]      r_fail_idx, w_fidx_nx;
   logic [DATA_W-1:0]     r_fail_data, w_fdata_nx;
   logic [CNT_W-1:0]      r_cycles, w_cycles_nx;

   logic [IDX_W-1:0]      w_sel;
   logic                  w_cand;
   logic                  w_hit;
   logic                  w_miss;
   logic [LEN_W-1:0]      w_len_sat;

   // Table has no reset so programmed expectations survive a mid-run abort.
   always_ff @(posedge clk) begin
      if (r_state == S_IDLE && cfg_we && {1'b0, cfg_idx} < LEN_W'(NUM_CHECKS)) begin
         r_addr[cfg_idx] <= cfg_addr;
         r_data[cfg_idx] <= cfg_data;
      end
   end

   assign w_len_sat = (cfg_len > LEN_W'(NUM_CHECKS)) ? LEN_W'(NUM_CHECKS) : cfg_len;

   // Candidate selection: ordered mode looks only at the next entry; unordered
   // mode takes the lowest-index unmatched active entry with a matching address.
   always_comb begin
      w_sel  = '0;
      w_cand = 1'b0;
      if (ORDERED != 0) begin
         w_sel  = r_match_count[IDX_W-1:0];
         w_cand = (r_match_count < r_len) && (r_addr[w_sel] == DataAdr);
      end else begin
         for (int unsigned i = 0; i < NUM_CHECKS; i++) begin
            if (!w_cand && LEN_W'(i) < r_len && !r_matched[i] && r_addr[i] == DataAdr) begin
               w_cand = 1'b1;
               w_sel  = IDX_W'(i);
            end
         end
      end
      w_hit  = (r_state == S_ARMED) && MemWriteM && w_cand && (r_data[w_sel] == WriteData);
      w_miss = (r_state == S_ARMED) && MemWriteM && w_cand && (r_data[w_sel] != WriteData);
   end

   always_comb begin
      w_state_nx   = r_state;
      w_len_nx     = r_len;
      w_mc_nx      = r_match_count;
      w_matched_nx = r_matched;
      w_fidx_nx    = r_fail_idx;
      w_fdata_nx   = r_fail_data;
      w_cycles_nx  = r_cycles;
      case (r_state)
         S_IDLE, S_PASS, S_FAIL, S_TOUT: begin
            if (start) begin
               w_state_nx   = S_ARMED;
               w_len_nx     = w_len_sat;
               w_mc_nx      = '0;
               w_matched_nx = '0;
               w_fidx_nx    = '0;
               w_fdata_nx   = '0;
               w_cycles_nx  = '0;
            end
         end
         S_ARMED: begin
            w_cycles_nx = r_cycles + CNT_W'(1);
            if (w_hit) begin
               w_mc_nx = r_match_count + LEN_W'(1);
               w_matched_nx[w_sel] = 1'b1;
            end
            // Verdict priority on a single edge: FAIL, then PASS, then TOUT.
            if (w_miss) begin
               w_state_nx = S_FAIL;
               w_fidx_nx  = w_sel;
               w_fdata_nx = WriteData;
            end else if (w_mc_nx == r_len) begin
               w_state_nx = S_PASS;
            end else if (r_cycles == CNT_W'(TIMEOUT - 1)) begin
               w_state_nx = S_TOUT;
            end
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state       <= S_IDLE;
         r_len         <= '0;
         r_match_count <= '0;
         r_matched     <= '0;
         r_fail_idx    <= '0;
         r_fail_data   <= '0;
         r_cycles      <= '0;
      end else begin
         r_state       <= w_state_nx;
         r_len         <= w_len_nx;
         r_match_count <= w_mc_nx;
         r_matched     <= w_matched_nx;
         r_fail_idx    <= w_fidx_nx;
         r_fail_data   <= w_fdata_nx;
         r_cycles      <= w_cycles_nx;
      end
   end

   assign pass        = (r_state == S_PASS);
   assign fail        = (r_state == S_FAIL);
   assign timeout     = (r_state == S_TOUT);
   assign done        = pass | fail | timeout;
   assign match_count = r_match_count;
   assign fail_idx    = r_fail_idx;
   assign fail_data   = r_fail_data;
   assign cycles      = r_cycles;

endmodule

// File: tb/tb_mem_write_checker.sv
module tb_mem_write_checker;

   localparam int TO   = 16;
   localparam int NCHK = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        cfg_we = 1'b0;
   logic [1:0]  cfg_idx = '0;
   logic [31:0] cfg_addr = '0;
   logic [31:0] cfg_data = '0;
   logic [2:0]  cfg_len = '0;
   logic        start = 1'b0;
   logic        MemWriteM = 1'b0;
   logic [31:0] DataAdr = '0;
   logic [31:0] WriteData = '0;

   // index 0: ordered instance, index 1: unordered instance
   logic [1:0]       done_w, pass_w, fail_w, to_w;
   logic [1:0][2:0]  mc_w;
   logic [1:0][1:0]  fi_w;
   logic [1:0][31:0] fd_w;
   logic [1:0][4:0]  cy_w;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mem_write_checker #(.ADDR_W(32), .DATA_W(32), .NUM_CHECKS(NCHK), .ORDERED(1), .TIMEOUT(TO)) u_ord (
      .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr),
      .cfg_data(cfg_data), .cfg_len(cfg_len), .start(start), .MemWriteM(MemWriteM),
      .DataAdr(DataAdr), .WriteData(WriteData), .done(done_w[0]), .pass(pass_w[0]),
      .fail(fail_w[0]), .timeout(to_w[0]), .match_count(mc_w[0]), .fail_idx(fi_w[0]),
      .fail_data(fd_w[0]), .cycles(cy_w[0]));

   mem_write_checker #(.ADDR_W(32), .DATA_W(32), .NUM_CHECKS(NCHK), .ORDERED(0), .TIMEOUT(TO)) u_uno (
      .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr),
      .cfg_data(cfg_data), .cfg_len(cfg_len), .start(start), .MemWriteM(MemWriteM),
      .DataAdr(DataAdr), .WriteData(WriteData), .done(done_w[1]), .pass(pass_w[1]),
      .fail(fail_w[1]), .timeout(to_w[1]), .match_count(mc_w[1]), .fail_idx(fi_w[1]),
      .fail_data(fd_w[1]), .cycles(cy_w[1]));

   // verdict codes: 0 none, 1 pass, 2 fail, 3 timeout, 9 inconsistent flags
   typedef struct {
      logic [3:0][31:0]  ta, td;
      int                len;
      logic [15:0][31:0] sa, sd;   // store at cycle t is element t-1; address 0 = no store
      int                ev0, ev1, mc0, mc1, cy0, cy1, fi, fd;
   } vec_t;

   vec_t vec [12];

   logic [3:0][31:0]  cur_ta, cur_td;
   logic [15:0][31:0] cur_sa, cur_sd;
   int                cur_len;

   int mdl_v  [2][21];
   int mdl_mc [2][21];
   int mdl_cy [2][21];
   int mdl_fi [2];
   int mdl_fd [2];

   function automatic logic [3:0][31:0] tab4(input logic [31:0] e0, e1, e2, e3);
      return {e3, e2, e1, e0};
   endfunction

   function automatic logic [15:0][31:0] seq4(input logic [31:0] s0, s1, s2, s3);
      return {{12{32'd0}}, s3, s2, s1, s0};
   endfunction

   function automatic int vcode(input int k);
      case ({done_w[k], pass_w[k], fail_w[k], to_w[k]})
         4'b0000: return 0;
         4'b1100: return 1;
         4'b1010: return 2;
         4'b1001: return 3;
         default: return 9;
      endcase
   endfunction

   task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d] actual=%0d required=%0d", nm, id, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic program_table();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      for (int i = 0; i < NCHK; i++) begin
         cfg_we   = 1'b1;
         cfg_idx  = 2'(i);
         cfg_addr = cur_ta[i];
         cfg_data = cur_td[i];
         tick();
      end
      cfg_we = 1'b0;
   endtask

   task automatic do_store(input logic [31:0] a, input logic [31:0] d);
      MemWriteM = 1'b1;
      DataAdr   = a;
      WriteData = d;
      tick();
      MemWriteM = 1'b0;
   endtask

   // Behavioural reference: walk the store list applying the matching rules.
   task automatic model_run();
      int L, cnt, v, cy, hit, fi;
      logic [31:0] fd;
      bit used [4];
      for (int m = 0; m < 2; m++) begin
         L = (cur_len > NCHK) ? NCHK : cur_len;
         cnt = 0; v = 0; cy = 0; fi = 0; fd = 0;
         for (int i = 0; i < 4; i++) used[i] = 1'b0;
         mdl_v[m][0] = 0; mdl_mc[m][0] = 0; mdl_cy[m][0] = 0;
         for (int t = 1; t <= 20; t++) begin
            if (v == 0) begin
               cy = t;
               if (t <= 16 && cur_sa[t-1] != 0) begin
                  hit = -1;
                  if (m == 0) begin
                     if (cnt < L && cur_ta[cnt] == cur_sa[t-1]) hit = cnt;
                  end else begin
                     for (int i = L - 1; i >= 0; i--)
                        if (!used[i] && cur_ta[i] == cur_sa[t-1]) hit = i;
                  end
                  if (hit >= 0) begin
                     if (cur_td[hit] == cur_sd[t-1]) begin
                        used[hit] = 1'b1;
                        cnt++;
                     end else begin
                        v = 2; fi = hit; fd = cur_sd[t-1];
                     end
                  end
               end
               if (v == 0 && cnt == L) v = 1;
               else if (v == 0 && t == TO) v = 3;
            end
            mdl_v[m][t] = v; mdl_mc[m][t] = cnt; mdl_cy[m][t] = cy;
         end
         mdl_fi[m] = fi; mdl_fd[m] = fd;
      end
   endtask

   // Program, start, then run exactly 20 cycles of stimulus (both instances
   // reach a verdict within TO cycles, so the window is naturally bounded).
   task automatic run_case(input bit percyc);
      program_table();
      cfg_len = 3'(cur_len);
      start = 1'b1;
      tick();
      start = 1'b0;
      if (percyc) for (int k = 0; k < 2; k++) begin
         chk("start_mc", k, 32'(mc_w[k]), 0);
         chk("start_verdict", k, vcode(k), 0);
      end
      for (int t = 1; t <= 20; t++) begin
         if (t <= 16 && cur_sa[t-1] != 0) begin
            MemWriteM = 1'b1; DataAdr = cur_sa[t-1]; WriteData = cur_sd[t-1];
         end else begin
            // address/data that would match entry 0 badly if the strobe were ignored
            MemWriteM = 1'b0; DataAdr = cur_ta[0]; WriteData = cur_td[0] ^ 32'd1;
         end
         tick();
         if (percyc) for (int k = 0; k < 2; k++) begin
            chk("cyc_mc", k, 32'(mc_w[k]), mdl_mc[k][t]);
            chk("cyc_verdict", k, vcode(k), mdl_v[k][t]);
         end
      end
      MemWriteM = 1'b0;
   endtask

   task automatic setv(input int i, input logic [3:0][31:0] ta, td, input int len,
                       input logic [15:0][31:0] sa, sd,
                       input int ev0, ev1, mc0, mc1, cy0, cy1, fi, fd);
      vec[i].ta = ta; vec[i].td = td; vec[i].len = len; vec[i].sa = sa; vec[i].sd = sd;
      vec[i].ev0 = ev0; vec[i].ev1 = ev1; vec[i].mc0 = mc0; vec[i].mc1 = mc1;
      vec[i].cy0 = cy0; vec[i].cy1 = cy1; vec[i].fi = fi; vec[i].fd = fd;
   endtask

   initial begin
      logic [3:0][31:0] ta_a, td_a, ta_b, td_b, ta_c, td_c, td_d;
      ta_a = tab4(100, 104, 1000, 1004); td_a = tab4(7, 9, 0, 0);
      ta_b = tab4(10, 11, 12, 13);       td_b = tab4(1, 2, 3, 4);
      ta_c = tab4(200, 200, 1000, 1004); td_c = tab4(5, 5, 0, 0);
      td_d = tab4(5, 6, 0, 0);

      //        table       len stores                                                         ev  ev  mc mc cy  cy  fi fd
      setv(0,  ta_a, td_a, 2, seq4(80, 100, 104, 0),  seq4(3, 7, 9, 0),                        1, 1, 2, 2, 3,  3,  0, 0);
      setv(1,  ta_a, td_a, 2, seq4(104, 100, 0, 0),   seq4(9, 7, 0, 0),                        3, 1, 1, 2, 16, 2,  0, 0);
      setv(2,  ta_a, td_a, 2, seq4(100, 0, 0, 0),     seq4(8, 0, 0, 0),                        2, 2, 0, 0, 1,  1,  0, 8);
      setv(3,  ta_c, td_c, 2, seq4(200, 200, 0, 0),   seq4(5, 5, 0, 0),                        1, 1, 2, 2, 2,  2,  0, 0);
      setv(4,  ta_c, td_d, 2, seq4(200, 0, 0, 0),     seq4(6, 0, 0, 0),                        2, 2, 0, 0, 1,  1,  0, 6);
      setv(5,  ta_a, td_a, 1, {32'd100, {15{32'd0}}}, {32'd7, {15{32'd0}}},                    1, 1, 1, 1, 16, 16, 0, 0);
      setv(6,  ta_a, td_a, 0, seq4(0, 0, 0, 0),       seq4(0, 0, 0, 0),                        1, 1, 0, 0, 1,  1,  0, 0);
      setv(7,  ta_b, td_b, 7, seq4(10, 11, 12, 13),   seq4(1, 2, 3, 4),                        1, 1, 4, 4, 4,  4,  0, 0);
      setv(8,  ta_b, td_b, 3, seq4(10, 11, 0, 0),     seq4(1, 9, 0, 0),                        2, 2, 1, 1, 2,  2,  1, 9);
      setv(9,  ta_b, td_b, 2, seq4(12, 10, 11, 0),    seq4(3, 1, 2, 0),                        1, 1, 2, 2, 3,  3,  0, 0);
      setv(10, ta_a, td_a, 2, seq4(100, 100, 0, 0),   seq4(7, 8, 0, 0),                        3, 3, 1, 1, 16, 16, 0, 0);
      setv(11, ta_a, td_a, 2, seq4(104, 100, 0, 0),   seq4(9, 8, 0, 0),                        2, 2, 0, 1, 2,  2,  0, 8);

      // reset state
      tick();
      for (int k = 0; k < 2; k++) begin
         chk("rst_verdict", k, vcode(k), 0);
         chk("rst_mc", k, 32'(mc_w[k]), 0);
         chk("rst_cycles", k, 32'(cy_w[k]), 0);
         chk("rst_fdata", k, fd_w[k], 0);
      end

      // table-driven scenarios
      for (int i = 0; i < 12; i++) begin
         cur_ta = vec[i].ta; cur_td = vec[i].td; cur_len = vec[i].len;
         cur_sa = vec[i].sa; cur_sd = vec[i].sd;
         run_case(1'b0);
         chk("vec_verdict_ord", i, vcode(0), vec[i].ev0);
         chk("vec_verdict_uno", i, vcode(1), vec[i].ev1);
         chk("vec_mc_ord", i, 32'(mc_w[0]), vec[i].mc0);
         chk("vec_mc_uno", i, 32'(mc_w[1]), vec[i].mc1);
         chk("vec_cycles_ord", i, 32'(cy_w[0]), vec[i].cy0);
         chk("vec_cycles_uno", i, 32'(cy_w[1]), vec[i].cy1);
         for (int k = 0; k < 2; k++) begin
            chk("vec_fail_idx", i * 2 + k, 32'(fi_w[k]), vec[i].fi);
            chk("vec_fail_data", i * 2 + k, fd_w[k], vec[i].fd);
         end
      end

      // reset asserted mid-ARMED, then re-start on the retained table
      cur_ta = ta_a; cur_td = td_a;
      program_table();
      cfg_len = 3'd2;
      start = 1'b1; tick(); start = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      reset = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("abort_verdict", k, vcode(k), 0);
         chk("abort_mc", k, 32'(mc_w[k]), 0);
         chk("abort_cycles", k, 32'(cy_w[k]), 0);
         chk("abort_fidx", k, 32'(fi_w[k]), 0);
         chk("abort_fdata", k, fd_w[k], 0);
      end
      tick();
      reset = 1'b1;
      start = 1'b1; tick(); start = 1'b0;
      do_store(100, 7);
      for (int k = 0; k < 2; k++) chk("rearm_mc1", k, 32'(mc_w[k]), 1);
      do_store(104, 9);
      for (int k = 0; k < 2; k++) begin
         chk("rearm_verdict", k, vcode(k), 1);
         chk("rearm_cycles", k, 32'(cy_w[k]), 2);
      end

      // table write attempted in PASS must be dropped
      cfg_we = 1'b1; cfg_idx = 2'd0; cfg_addr = 100; cfg_data = 555;
      tick();
      cfg_we = 1'b0;
      start = 1'b1; cfg_len = 3'd2; tick(); start = 1'b0;
      for (int k = 0; k < 2; k++) chk("restart_cycles", k, 32'(cy_w[k]), 0);
      do_store(100, 7);
      do_store(104, 9);
      for (int k = 0; k < 2; k++) begin
         chk("cfg_in_pass_verdict", k, vcode(k), 1);
         chk("cfg_in_pass_mc", k, 32'(mc_w[k]), 2);
      end

      // randomized scenarios against the reference model
      for (int r = 0; r < 30; r++) begin
         cur_len = int'($urandom_range(0, 5));
         for (int i = 0; i < NCHK; i++) begin
            cur_ta[i] = 32'h40 + 32'($urandom_range(0, 3));
            cur_td[i] = ($urandom_range(0, 3) == 0) ? 32'd2 : 32'd1;
         end
         for (int s = 0; s < 16; s++) begin
            cur_sa[s] = ($urandom_range(0, 2) == 0) ? 32'd0 : 32'h40 + 32'($urandom_range(0, 4));
            cur_sd[s] = ($urandom_range(0, 3) == 0) ? 32'd2 : 32'd1;
         end
         model_run();
         run_case(1'b1);
         for (int k = 0; k < 2; k++) begin
            chk("rnd_cycles", r * 2 + k, 32'(cy_w[k]), mdl_cy[k][20]);
            if (mdl_v[k][20] == 2) begin
               chk("rnd_fail_idx", r * 2 + k, 32'(fi_w[k]), mdl_fi[k]);
               chk("rnd_fail_data", r * 2 + k, fd_w[k], mdl_fd[k]);
            end else begin
               chk("rnd_fail_data_clr", r * 2 + k, fd_w[k], 0);
            end
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
